// File: rtl/tc_pkg.sv
// tc_pkg: shared types and payload field layout for the traffic checker.
// Field map: seq in the low COUNT_WIDTH bits, pad up to the midpoint,
// send timestamp in the upper half of tdata.
package tc_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUNNING  = 2'd1,
    FINISHED = 2'd2
  } tc_state_e;

  // Sequence number always starts at bit 0.
  localparam int SEQ_LSB = 0;

  // Pad begins right after the sequence field.
  function automatic int pad_lsb(input int count_width);
    return count_width;
  endfunction

  // Timestamp occupies the upper half of the data word.
  function automatic int stamp_lsb(input int tdata_width);
    return tdata_width / 2;
  endfunction

endpackage

// File: rtl/lfsr16_sr.sv
// lfsr16_sr: 16-bit Fibonacci LFSR, XNOR taps 16/15/13/4, shifts left.
// Latency: new value one cycle after each enabled edge.
// Backpressure: none; ena_i gates stepping.
// Ports: clk_i clock, rst_i sync active-high reset to SEED, ena_i step enable, q_o state.
module lfsr16_sr #(
  parameter logic [15:0] SEED = 16'hB5C3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ena_i,
  output logic [15:0] q_o
);

  logic [15:0] q_q;

  // XNOR feedback: the all-ones word is the lockup state and is never reached.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= SEED;
    end else if (ena_i) begin
      q_q <= {q_q[14:0], ~(q_q[15] ^ q_q[14] ^ q_q[12] ^ q_q[3])};
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/axis_tc.sv
// axis_tc: AXI-Stream traffic sink checking per-source sequence, format and latency.
// Latency: all statistics update on the accepting edge, visible the next cycle.
// Backpressure: tready from registered state and LFSR only (random load), never from tvalid.
// Ports: clk/rst, run control (ready_load, num_packets, start, done), timestamp ticks,
// statistics (recv_packets, seq_errors, fmt_errors, lat_sum/min/max), axis_in_* sink.
module axis_tc
  import tc_pkg::*;
#(
  parameter logic [15:0] READY_SEED = 16'hB5C3,
  parameter int COUNT_WIDTH = 32,
  parameter int LAT_WIDTH   = 32,
  parameter int SUM_WIDTH   = 64,
  parameter int TDATA_WIDTH = 512,
  parameter int TDEST_WIDTH = 2,
  parameter int TID_WIDTH   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [15:0]              ready_load,
  input  logic [COUNT_WIDTH-1:0]   num_packets,
  input  logic                     start,
  input  logic [TDATA_WIDTH/2-1:0] ticks,
  output logic                     done,
  output logic [COUNT_WIDTH-1:0]   recv_packets [2**TID_WIDTH],
  output logic [COUNT_WIDTH-1:0]   seq_errors,
  output logic [COUNT_WIDTH-1:0]   fmt_errors,
  output logic [SUM_WIDTH-1:0]     lat_sum,
  output logic [LAT_WIDTH-1:0]     lat_min,
  output logic [LAT_WIDTH-1:0]     lat_max,
  input  logic                     axis_in_tvalid,
  output logic                     axis_in_tready,
  input  logic [TDATA_WIDTH-1:0]   axis_in_tdata,
  input  logic                     axis_in_tlast,
  input  logic [TID_WIDTH-1:0]     axis_in_tid,
  input  logic [TDEST_WIDTH-1:0]   axis_in_tdest
);

  localparam int NSRC     = 2**TID_WIDTH;
  localparam int PadLsb   = pad_lsb(COUNT_WIDTH);
  localparam int StampLsb = stamp_lsb(TDATA_WIDTH);
  localparam int HalfW    = TDATA_WIDTH / 2;

  tc_state_e              state_q, state_d;
  logic [COUNT_WIDTH-1:0] total_q, total_d;
  logic [COUNT_WIDTH-1:0] recv_q [NSRC];
  logic [COUNT_WIDTH-1:0] recv_d [NSRC];
  logic [COUNT_WIDTH-1:0] exp_q  [NSRC];
  logic [COUNT_WIDTH-1:0] exp_d  [NSRC];
  logic [COUNT_WIDTH-1:0] seq_err_q, seq_err_d;
  logic [COUNT_WIDTH-1:0] fmt_err_q, fmt_err_d;
  logic [SUM_WIDTH-1:0]   sum_q, sum_d;
  logic [LAT_WIDTH-1:0]   min_q, min_d;
  logic [LAT_WIDTH-1:0]   max_q, max_d;

  logic [15:0]            lfsr_q;
  logic                   accept;
  logic [COUNT_WIDTH-1:0] seq;
  logic                   pad_nz;
  logic [HalfW-1:0]       diff;
  logic [LAT_WIDTH-1:0]   lat;
  logic [SUM_WIDTH:0]     sum_ext;
  logic                   unused_bits;

  lfsr16_sr #(.SEED(READY_SEED)) u_lfsr (
    .clk_i (clk),
    .rst_i (rst),
    .ena_i (1'b1),
    .q_o   (lfsr_q)
  );

  assign seq     = axis_in_tdata[SEQ_LSB +: COUNT_WIDTH];
  assign pad_nz  = |axis_in_tdata[StampLsb-1:PadLsb];
  // Full-width modular difference handles ticks wrap; only the low bits are kept.
  assign diff    = ticks - axis_in_tdata[TDATA_WIDTH-1:StampLsb];
  assign lat     = diff[LAT_WIDTH-1:0];
  assign sum_ext = {1'b0, sum_q} + (SUM_WIDTH+1)'(lat);
  assign unused_bits = ^{axis_in_tdest, diff[HalfW-1:LAT_WIDTH]};

  assign axis_in_tready = (state_q == RUNNING) && (lfsr_q < ready_load) &&
                          (total_q < num_packets);
  assign accept = axis_in_tvalid & axis_in_tready;

  always_comb begin
    state_d   = state_q;
    total_d   = total_q;
    recv_d    = recv_q;
    exp_d     = exp_q;
    seq_err_d = seq_err_q;
    fmt_err_d = fmt_err_q;
    sum_d     = sum_q;
    min_d     = min_q;
    max_d     = max_q;
    case (state_q)
      IDLE, FINISHED: begin
        if (start) begin
          state_d   = RUNNING;
          total_d   = '0;
          seq_err_d = '0;
          fmt_err_d = '0;
          sum_d     = '0;
          min_d     = '1;
          max_d     = '0;
          for (int i = 0; i < NSRC; i++) begin
            recv_d[i] = '0;
            exp_d[i]  = '0;
          end
        end
      end
      RUNNING: begin
        if (accept) begin
          total_d = total_q + COUNT_WIDTH'(1);
          recv_d[axis_in_tid] = recv_q[axis_in_tid] + COUNT_WIDTH'(1);
          // On mismatch, resync to the received sequence so one gap costs one error.
          if (seq != exp_q[axis_in_tid]) begin
            seq_err_d = seq_err_q + COUNT_WIDTH'(1);
          end
          exp_d[axis_in_tid] = seq + COUNT_WIDTH'(1);
          if (!axis_in_tlast || pad_nz) begin
            fmt_err_d = fmt_err_q + COUNT_WIDTH'(1);
          end
          sum_d = sum_ext[SUM_WIDTH] ? '1 : sum_ext[SUM_WIDTH-1:0];
          if (lat < min_q) min_d = lat;
          if (lat > max_q) max_d = lat;
        end
        // Also covers num_packets == 0: one RUNNING cycle with no accepts.
        if (total_d == num_packets) begin
          state_d = FINISHED;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      total_q   <= '0;
      seq_err_q <= '0;
      fmt_err_q <= '0;
      sum_q     <= '0;
      min_q     <= '1;
      max_q     <= '0;
      for (int i = 0; i < NSRC; i++) begin
        recv_q[i] <= '0;
        exp_q[i]  <= '0;
      end
    end else begin
      state_q   <= state_d;
      total_q   <= total_d;
      seq_err_q <= seq_err_d;
      fmt_err_q <= fmt_err_d;
      sum_q     <= sum_d;
      min_q     <= min_d;
      max_q     <= max_d;
      recv_q    <= recv_d;
      exp_q     <= exp_d;
    end
  end

  assign done         = (state_q == FINISHED);
  assign recv_packets = recv_q;
  assign seq_errors   = seq_err_q;
  assign fmt_errors   = fmt_err_q;
  assign lat_sum      = sum_q;
  assign lat_min      = min_q;
  assign lat_max      = max_q;

endmodule

// File: tb/tb_axis_tc.sv
// tb_axis_tc: directed self-checking bench for axis_tc.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
module tb_axis_tc;

  logic         clk;
  logic         rst;
  logic [15:0]  ready_load;
  logic [31:0]  num_packets;
  logic         start;
  logic [255:0] ticks;
  logic         done;
  logic [31:0]  recv [4];
  logic [31:0]  seq_errors;
  logic [31:0]  fmt_errors;
  logic [63:0]  lat_sum;
  logic [31:0]  lat_min;
  logic [31:0]  lat_max;
  logic         tvalid;
  logic         tready;
  logic [511:0] tdata;
  logic         tlast;
  logic [1:0]   tid;
  logic [1:0]   tdest;

  int checks = 0;
  int passes = 0;

  axis_tc dut (
    .clk            (clk),
    .rst            (rst),
    .ready_load     (ready_load),
    .num_packets    (num_packets),
    .start          (start),
    .ticks          (ticks),
    .done           (done),
    .recv_packets   (recv),
    .seq_errors     (seq_errors),
    .fmt_errors     (fmt_errors),
    .lat_sum        (lat_sum),
    .lat_min        (lat_min),
    .lat_max        (lat_max),
    .axis_in_tvalid (tvalid),
    .axis_in_tready (tready),
    .axis_in_tdata  (tdata),
    .axis_in_tlast  (tlast),
    .axis_in_tid    (tid),
    .axis_in_tdest  (tdest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [31:0] n);
    num_packets = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send(input logic [1:0] id, input logic [31:0] sq, input logic [255:0] st,
                      input logic last, input logic [223:0] pd);
    int n;
    tid    = id;
    tdata  = {st, pd, sq};
    tlast  = last;
    tvalid = 1'b1;
    n = 0;
    while (!tready && n < 100) begin
      tick();
      n++;
    end
    chk("accept_wait", 64'(n < 100), 64'd1);
    tick();
    tvalid = 1'b0;
    tlast  = 1'b1;
  endtask

  initial begin
    int cnt;
    logic [223:0] pad40;
    logic [255:0] wstamp;
    rst = 1'b1; ready_load = 16'hFFFF; num_packets = 32'd0; start = 1'b0;
    ticks = 256'd110; tvalid = 1'b0; tdata = '0; tlast = 1'b1; tid = 2'd0; tdest = 2'd0;
    repeat (3) tick();
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_tready", 64'(tready), 64'd0);
    chk("rst_lat_min", 64'(lat_min), 64'hFFFF_FFFF);
    chk("rst_lat_max", 64'(lat_max), 64'd0);
    chk("rst_lat_sum", lat_sum, 64'd0);
    chk("rst_recv1", 64'(recv[1]), 64'd0);
    rst = 1'b0;
    tick();
    chk("idle_tready", 64'(tready), 64'd0);

    // Run 1: 8 beats on tid 1, latencies 10 down to 3.
    pulse_start(32'd8);
    for (int i = 0; i < 8; i++) send(2'd1, 32'(i), 256'(100 + i), 1'b1, '0);
    chk("r1_recv1", 64'(recv[1]), 64'd8);
    chk("r1_seq", 64'(seq_errors), 64'd0);
    chk("r1_fmt", 64'(fmt_errors), 64'd0);
    chk("r1_min", 64'(lat_min), 64'd3);
    chk("r1_max", 64'(lat_max), 64'd10);
    chk("r1_sum", lat_sum, 64'd52);
    chk("r1_done", 64'(done), 64'd1);
    chk("r1_tready", 64'(tready), 64'd0);

    // Sequence gap on tid 2, restart from FINISHED clears stats.
    pulse_start(32'd4);
    chk("gap_clr_recv1", 64'(recv[1]), 64'd0);
    chk("gap_clr_min", 64'(lat_min), 64'hFFFF_FFFF);
    chk("gap_done0", 64'(done), 64'd0);
    send(2'd2, 32'd0, 256'd100, 1'b1, '0);
    send(2'd2, 32'd1, 256'd100, 1'b1, '0);
    send(2'd2, 32'd3, 256'd100, 1'b1, '0);
    chk("gap_seq_at3", 64'(seq_errors), 64'd1);
    send(2'd2, 32'd4, 256'd100, 1'b1, '0);
    chk("gap_seq_at4", 64'(seq_errors), 64'd1);
    chk("gap_recv2", 64'(recv[2]), 64'd4);
    chk("gap_done", 64'(done), 64'd1);

    // Format errors: tlast low, pad bit 40, then both on one beat.
    pad40 = '0;
    pad40[8] = 1'b1;
    pulse_start(32'd3);
    send(2'd0, 32'd0, 256'd100, 1'b0, '0);
    send(2'd0, 32'd1, 256'd100, 1'b1, pad40);
    chk("fmt_two", 64'(fmt_errors), 64'd2);
    chk("fmt_seq", 64'(seq_errors), 64'd0);
    send(2'd0, 32'd2, 256'd100, 1'b0, pad40);
    chk("fmt_both_once", 64'(fmt_errors), 64'd3);

    // Backpressure: zero load holds tready low.
    ready_load = 16'h0000;
    pulse_start(32'd100000);
    tid = 2'd3; tdata = '0; tlast = 1'b1; tvalid = 1'b1;
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      if (tready) cnt++;
      tick();
    end
    chk("bp0_tready_cycles", 64'(cnt), 64'd0);
    chk("bp0_recv3", 64'(recv[3]), 64'd0);
    chk("bp0_seq", 64'(seq_errors), 64'd0);
    chk("bp0_done", 64'(done), 64'd0);

    // Half load: accept ratio within 45..55 % of 4096 cycles.
    ready_load = 16'h8000;
    cnt = 0;
    for (int i = 0; i < 4096; i++) begin
      if (tready) cnt++;
      tick();
    end
    tvalid = 1'b0;
    chk("bp50_ratio", 64'(cnt >= 1843 && cnt <= 2252), 64'd1);
    chk("bp50_recv3", 64'(recv[3]), 64'(cnt));

    // Reset mid-run after 3 beats, with a 4th beat presented in the reset cycle.
    rst = 1'b1; tick(); rst = 1'b0;
    ready_load = 16'hFFFF;
    pulse_start(32'd8);
    for (int i = 0; i < 3; i++) send(2'd1, 32'(i), 256'd100, 1'b1, '0);
    chk("mid_recv1_pre", 64'(recv[1]), 64'd3);
    send_in_reset: begin
      tid = 2'd1; tdata = {256'd100, 224'd0, 32'd3}; tvalid = 1'b1; rst = 1'b1;
      tick();
      rst = 1'b0; tvalid = 1'b0;
    end
    chk("mid_recv1", 64'(recv[1]), 64'd0);
    chk("mid_min", 64'(lat_min), 64'hFFFF_FFFF);
    chk("mid_max", 64'(lat_max), 64'd0);
    chk("mid_sum", lat_sum, 64'd0);
    chk("mid_done", 64'(done), 64'd0);
    chk("mid_tready_idle", 64'(tready), 64'd0);

    // num_packets = 0: one RUNNING cycle with tready low, then FINISHED.
    pulse_start(32'd0);
    chk("np0_tready", 64'(tready), 64'd0);
    chk("np0_done_early", 64'(done), 64'd0);
    tick();
    chk("np0_done", 64'(done), 64'd1);
    chk("np0_recv_all", 64'(recv[0] + recv[1] + recv[2] + recv[3]), 64'd0);

    // Ticks wrap: ticks 2, stamp 2**256-3 gives latency 5.
    wstamp = '1;
    wstamp = wstamp - 256'd2;
    ticks = 256'd2;
    pulse_start(32'd1);
    send(2'd0, 32'd0, wstamp, 1'b1, '0);
    chk("wrap_min", 64'(lat_min), 64'd5);
    chk("wrap_max", 64'(lat_max), 64'd5);
    chk("wrap_sum", lat_sum, 64'd5);
    ticks = 256'd110;

    // Restart from FINISHED: counters cleared, a fresh run from seq 0 is clean.
    pulse_start(32'd4);
    chk("rs_recv0_clr", 64'(recv[0]), 64'd0);
    chk("rs_min_clr", 64'(lat_min), 64'hFFFF_FFFF);
    for (int i = 0; i < 4; i++) send(2'd0, 32'(i), 256'd105, 1'b1, '0);
    chk("rs_seq", 64'(seq_errors), 64'd0);
    chk("rs_recv0", 64'(recv[0]), 64'd4);
    chk("rs_sum", lat_sum, 64'd20);
    chk("rs_done", 64'(done), 64'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/axis_tc.md
Name: axis_tc

Overview:
- Traffic checker/sink at the egress of a NoC port; the receive end of the uniform-random traffic generator's AXI-Stream flow.
- Accepts single-beat packets with a randomized ready load, checks per-source sequence numbers and the payload format, and measures latency from an embedded send timestamp.
- Exposes per-source counts, error counts and latency statistics to the test harness.

Parameters:
- READY_SEED, 16'hB5C3, seed for the ready-load LFSR.
- COUNT_WIDTH, 32, width of packet counters and of the embedded sequence field.
- LAT_WIDTH, 32, latency width; latency is taken modulo 2**LAT_WIDTH.
- SUM_WIDTH, 64, width of the latency accumulator.
- TDATA_WIDTH, 512, stream data width, even, at least 2*COUNT_WIDTH.
- TDEST_WIDTH, 2, stream dest width; tdest is ignored.
- TID_WIDTH, 2, stream id width; NSRC = 2**TID_WIDTH sources.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- ready_load  in  16  tready asserted when lfsr < ready_load; 16'hFFFF is about 100%.
- num_packets  in  COUNT_WIDTH  expected total packets for the run.
- start  in  1  begins a run; single-cycle pulse.
- ticks  in  TDATA_WIDTH/2  free-running timestamp shared with the senders.
- done  out  1  run complete.
- recv_packets[NSRC]  out  COUNT_WIDTH each  packets accepted per tid.
- seq_errors  out  COUNT_WIDTH  sequence mismatches.
- fmt_errors  out  COUNT_WIDTH  format violations.
- lat_sum  out  SUM_WIDTH  saturating sum of latencies.
- lat_min  out  LAT_WIDTH  minimum latency.
- lat_max  out  LAT_WIDTH  maximum latency.
- axis_in_tvalid  in  1  beat valid.
- axis_in_tready  out  1  beat ready.
- axis_in_tdata  in  TDATA_WIDTH  packet payload.
- axis_in_tlast  in  1  end of packet.
- axis_in_tid  in  TID_WIDTH  source id.
- axis_in_tdest  in  TDEST_WIDTH  dest, ignored.

Behaviour:
- Reset: one clock, clk; reset is synchronous and active-high (rst).
  - On rst: state IDLE, all counters 0, lat_sum 0, lat_min all-ones, lat_max 0, done 0, tready 0.
  - LFSR loads READY_SEED and expected sequence numbers clear.
  - rst mid-run aborts with the same values; a beat presented in that cycle is not counted.
- Payload fields:
  - seq = tdata[COUNT_WIDTH-1:0].
  - stamp = tdata[TDATA_WIDTH-1:TDATA_WIDTH/2].
  - pad = tdata[TDATA_WIDTH/2-1:COUNT_WIDTH].
- States:
  - IDLE: tready 0, done 0; start moves to RUNNING.
  - RUNNING: tready = (lfsr_q < ready_load) and (total < num_packets). Here total is the internal sum of accepted beats.
  - RUNNING moves to FINISHED on the edge after which total == num_packets.
  - num_packets == 0: RUNNING lasts one cycle with tready 0, then FINISHED.
  - FINISHED: done 1, tready 0, stats held.
  - start in IDLE or FINISHED: clears all stats, expected-seq table and total on the same edge, then enters RUNNING. start in RUNNING is ignored.
- tready is combinational from registered state and LFSR only, never from tvalid.
- The LFSR advances every cycle when not in reset.
- Accept = tvalid & tready. All updates land on the accepting edge; outputs are registered and visible the next cycle.
- Per accept with source s = tid:
  - recv_packets[s] += 1 and total += 1.
  - If seq == exp[s]: exp[s] <= exp[s]+1. Otherwise seq_errors += 1 and exp[s] <= seq+1 (resync).
  - If tlast == 0 or pad != 0: fmt_errors += 1. One increment per beat, even when both conditions hold.
  - lat = (ticks - stamp) truncated to LAT_WIDTH, unsigned modular; this covers ticks wrap.
  - lat_sum += lat, saturating at all-ones.
  - lat_min = min(lat_min, lat) and lat_max = max(lat_max, lat), both updated on the same edge.
- Counter wrap: recv/error counters wrap modulo 2**COUNT_WIDTH. exp[] wraps identically, so a sender wrap is not an error.
- tvalid while tready is 0: no state change. The sender holds the beat.

Decomposition:
- Package tc_pkg:
  - state enum {IDLE, RUNNING, FINISHED}.
  - Field-offset localparams for seq, pad and stamp, shared with the generator side.
- Sub-module lfsr16_sr: 16-bit Fibonacci LFSR with sync active-high reset to SEED and an ena input.
  - Shift left; q[0] <= ~(q[15]^q[14]^q[12]^q[3]).
  - Instantiated once with ena = 1.

Test Plan:
- Run 1: ready_load=16'hFFFF, num_packets=8, tid=1, seq 0..7, stamps 100..107, each beat accepted at tick 110.
  - Expect recv_packets[1]=8, seq_errors=0, lat_min=3, lat_max=10, lat_sum=52, done=1.
- Sequence gap: tid=2 sends seq 0,1,3,4.
  - Expect seq_errors=1 (at seq 3) and no error at 4; recv_packets[2]=4.
- Format errors: one beat with tlast=0 and one with pad bit 40 set, num_packets=2.
  - Expect fmt_errors=2 and seq_errors=0.
- Backpressure:
  - ready_load=16'h0000: tready stays 0 for 1000 cycles with tvalid=1; no counts change.
  - ready_load=16'h8000: the measured accept ratio over 4096 cycles is within 0.45 to 0.55.
- Boundaries:
  - num_packets=0: FINISHED two cycles after start with zero accepts.
  - ticks wrapped to 2, stamp = 2**256-3: lat=5.
  - rst asserted mid-run after 3 beats: all outputs return to reset values and state is IDLE.
- Restart: start in FINISHED clears recv_packets and lat_min to all-ones. A second 4-packet run starting at seq 0 gives no seq_errors.
